// File: rtl/msx_mapper_pkg.sv
`default_nettype none
//============================================================================
// Module      : msx_mapper_pkg
// Description : Shared definitions for the MSX2 memory-mapper RAM controller:
//               default I/O base, page-index type and the reset segment
//               assignment for each CPU page.
// Revision    : 1.0  initial release
//============================================================================
package msx_mapper_pkg;

    // First of the four mapper I/O ports (0xFC..0xFF -> pages 0..3)
    localparam logic [7:0] MAPPER_IO_BASE = 8'hFC;

    // CPU page index, addr[15:14] for memory, addr[1:0] for mapper ports
    typedef logic [1:0] page_t;

    // Power-up mapping: page p gets segment 3-p, masked to the segment width
    // so small RAM configurations still start with legal segment numbers.
    function automatic logic [7:0] reset_seg(input page_t p, input int unsigned seg_bits);
        logic [7:0] v_val;
        logic [7:0] v_mask;
        v_val  = 8'd3 - {6'd0, p};
        v_mask = 8'((9'd1 << seg_bits) - 9'd1);
        return v_val & v_mask;
    endfunction

endpackage : msx_mapper_pkg
`default_nettype wire

// File: rtl/msx_strobe_sync.sv
`default_nettype none
//============================================================================
// Module      : msx_strobe_sync
// Description : Two-flop synchroniser followed by a previous-value flop.
//               'pulse' is high for one clk when the synchronised request
//               goes from inactive to active (i.e. the bus strobe falls).
// Ports       : clk, rst (async, active-high), async_in (active-high
//               request), pulse (one-cycle event)
// Parameters  : RST_VAL - reset value of all three flops. Resetting to the
//               asserted level means a request already active when reset
//               is released cannot produce a pulse.
// Revision    : 1.0  initial release
//============================================================================
module msx_strobe_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic pulse
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= RST_VAL;
            r_sync2 <= RST_VAL;
            r_prev  <= RST_VAL;
        end else begin
            r_sync1 <= async_in;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign pulse = r_sync2 & ~r_prev;

endmodule : msx_strobe_sync
`default_nettype wire

// File: rtl/msx_mapper_ram.sv
`default_nettype none
//============================================================================
// Module      : msx_mapper_ram
// Description : MSX2-style memory mapper for slot 3. Four page registers,
//               written through I/O ports IO_BASE..IO_BASE+3, select which
//               16 KB SRAM segment appears in each 16 KB CPU page. The
//               memory path is purely combinational; register writes are
//               taken from a synchronised I/O write strobe.
// Ports       : clk, rst (async, active-high)
//               nsltsel3, niorq, nrd, nwr  - Z80 bus controls (active-low)
//               addr[15:0], data_in[7:0]   - Z80 address / data in
//               data_out[7:0], data_oe     - register readback to the bus
//               ram_addr[SEG_BITS+13:0]    - SRAM address
//               ram_nce, ram_noe, ram_nwe  - SRAM controls (active-low)
// Config      : MSX_MAPPER_READBACK_EN - when defined, I/O reads of the
//               mapper ports return {1s above SEG_BITS, seg[k]}; otherwise
//               the mapper is write-only and data_oe/data_out are tied 0.
// Revision    : 1.0  initial release
//============================================================================
module msx_mapper_ram
    import msx_mapper_pkg::*;
#(
    parameter int unsigned SEG_BITS = 3,
    parameter logic [7:0]  IO_BASE  = MAPPER_IO_BASE
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   nsltsel3,
    input  logic                   niorq,
    input  logic                   nrd,
    input  logic                   nwr,
    input  logic [15:0]            addr,
    input  logic [7:0]             data_in,
    output logic [7:0]             data_out,
    output logic                   data_oe,
    output logic [SEG_BITS+13:0]   ram_addr,
    output logic                   ram_nce,
    output logic                   ram_noe,
    output logic                   ram_nwe
);

    logic [SEG_BITS-1:0] r_seg [4];
    logic                w_port_hit;
    logic                w_io_wr;
    logic                w_wr_fire;
    page_t               w_mem_page;
    page_t               w_io_page;
    logic                w_unused_data;

    // Only addr[7:2] is decoded; addr[15:8] carries the A register on OUT.
    assign w_port_hit = (addr[7:2] == IO_BASE[7:2]);
    assign w_io_wr    = ~niorq & ~nwr & w_port_hit;
    assign w_io_page  = addr[1:0];
    assign w_mem_page = addr[15:14];

    // Data bits above the segment width are intentionally discarded.
    assign w_unused_data = ^data_in;

    msx_strobe_sync #(
        .RST_VAL (1'b1)
    ) u_wr_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (w_io_wr),
        .pulse    (w_wr_fire)
    );

    // addr and data_in are sampled directly: the Z80 holds them stable for
    // the whole nwr pulse, which outlasts the synchroniser latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                r_seg[i] <= SEG_BITS'(reset_seg(page_t'(i), SEG_BITS));
            end
        end else if (w_wr_fire) begin
            r_seg[w_io_page] <= data_in[SEG_BITS-1:0];
        end
    end

    // Memory path: no clock in the way, SRAM sees the mapped address at once.
    assign ram_addr = {r_seg[w_mem_page], addr[13:0]};
    assign ram_nce  = nsltsel3 | ~niorq;
    assign ram_noe  = nrd | ram_nce;
    assign ram_nwe  = nwr | ram_nce;

`ifdef MSX_MAPPER_READBACK_EN
    logic [7:0] w_rb_val;
    logic [7:0] r_data_out;

    always_comb begin
        w_rb_val                 = '1;
        w_rb_val[SEG_BITS-1:0]   = r_seg[w_io_page];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data_out <= '0;
        end else begin
            r_data_out <= w_rb_val;
        end
    end

    assign data_out = r_data_out;
    assign data_oe  = ~niorq & ~nrd & w_port_hit;
`else
    assign data_out = '0;
    assign data_oe  = 1'b0;
`endif

endmodule : msx_mapper_ram
`default_nettype wire

// File: tb/tb_msx_mapper_ram.sv
`default_nettype none
//============================================================================
// Module      : tb_msx_mapper_ram
// Description : Self-checking bench for msx_mapper_ram (SEG_BITS=3). Keeps
//               a reference table of the four page segments, updated per
//               completed OUT instruction, and compares the memory path,
//               SRAM strobes and (optionally) register readback against it.
// Revision    : 1.0  initial release
//============================================================================
module tb_msx_mapper_ram;

    localparam int unsigned SB = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          nsltsel3, niorq, nrd, nwr;
    logic [15:0]   addr;
    logic [7:0]    data_in;
    logic [7:0]    data_out;
    logic          data_oe;
    logic [SB+13:0] ram_addr;
    logic          ram_nce, ram_noe, ram_nwe;

    int total = 0;
    int bad   = 0;

    // Reference model: segment currently mapped to each page
    logic [SB-1:0] mseg [4];

    always #5 clk = ~clk;

    msx_mapper_ram #(
        .SEG_BITS (SB),
        .IO_BASE  (8'hFC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .nsltsel3 (nsltsel3),
        .niorq    (niorq),
        .nrd      (nrd),
        .nwr      (nwr),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out),
        .data_oe  (data_oe),
        .ram_addr (ram_addr),
        .ram_nce  (ram_nce),
        .ram_noe  (ram_noe),
        .ram_nwe  (ram_nwe)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mseg[0] = 3'd3; mseg[1] = 3'd2; mseg[2] = 3'd1; mseg[3] = 3'd0;
    endtask

    function automatic logic [SB+13:0] map_addr(input logic [15:0] a);
        return {mseg[a[15:14]], a[13:0]};
    endfunction

    // Advance to just after the next rising edge (input drive point)
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        nsltsel3 = 1'b1; niorq = 1'b1; nrd = 1'b1; nwr = 1'b1;
        addr = 16'h0000; data_in = 8'h00;
    endtask

    // Slot-3 memory read; expected address given explicitly
    task automatic mem_rd(input string tag, input logic [15:0] a, input logic [SB+13:0] exp);
        addr = a; nsltsel3 = 1'b0; niorq = 1'b1; nrd = 1'b0; nwr = 1'b1;
        @(negedge clk);
        check(tag, {ram_nce, ram_noe, ram_nwe, ram_addr}, {3'b001, exp});
        nrd = 1'b1; nsltsel3 = 1'b1;
    endtask

    // OUT (port),d with A=hi on addr[15:8]; strobes low lo clk, high hiw clk
    task automatic io_out(input logic [7:0] port, input logic [7:0] hi, input logic [7:0] d,
                          input int lo, input int hiw);
        tick();
        addr = {hi, port}; data_in = d; niorq = 1'b0; nwr = 1'b0;
        @(negedge clk);
        check("io_nce", {ram_nce, ram_noe, ram_nwe}, 3'b111);
        repeat (lo) tick();
        niorq = 1'b1; nwr = 1'b1;
        repeat (hiw) tick();
        if (port[7:2] == 6'h3F) mseg[port[1:0]] = d[SB-1:0];
    endtask

    // IN (IO_BASE+k): readback value depends on the build option
    task automatic io_in(input logic [1:0] k);
        logic [7:0] exp_d;
        logic       exp_oe;
`ifdef MSX_MAPPER_READBACK_EN
        exp_d  = 8'hFF;
        exp_d[SB-1:0] = mseg[k];
        exp_oe = 1'b1;
`else
        exp_d  = 8'h00;
        exp_oe = 1'b0;
`endif
        tick();
        addr = {8'($urandom_range(0, 255)), 6'h3F, k}; niorq = 1'b0; nrd = 1'b0;
        tick();
        @(negedge clk);
        check("rb", {23'd0, data_oe, data_out}, {23'd0, exp_oe, exp_d});
        niorq = 1'b1; nrd = 1'b1;
    endtask

    initial begin
        bus_idle();
        rst = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_dout", {23'd0, data_oe, data_out}, 32'd0);
        mem_rd("rst_p0", 16'h0000, 17'h0C000);
        mem_rd("rst_p1", 16'h4000, 17'h08000);
        mem_rd("rst_p2", 16'h8000, 17'h04000);
        mem_rd("rst_p3", 16'hC000, 17'h00000);

        // OUT (0xFE),5 with A=0x80 so the bus sits on page 2 during the write:
        // the new segment must appear exactly after the third edge that sees it
        tick();
        addr = 16'h80FE; data_in = 8'h05; niorq = 1'b0; nwr = 1'b0;
        @(negedge clk); check("lat_a", 32'(ram_addr), 32'h040FE);
        @(negedge clk); check("lat_b", 32'(ram_addr), 32'h040FE);
        @(negedge clk); check("lat_c", 32'(ram_addr), 32'h040FE);
        @(negedge clk); check("lat_d", 32'(ram_addr), 32'h140FE);
        tick();
        niorq = 1'b1; nwr = 1'b1;
        repeat (2) tick();
        mseg[2] = 3'd5;
        mem_rd("out_fe", 16'h8123, 17'h14123);

        // Upper data bits discarded
        io_out(8'hFD, 8'h00, 8'hFF, 3, 2);
        mem_rd("out_fd", 16'h7FFF, 17'h1FFFF);

        // Readback, nsltsel3 held high during the write
        io_out(8'hFF, 8'h00, 8'h06, 3, 2);
        io_in(2'd3);

        // Long strobe with data changing mid-pulse: a single write of 0x02
        tick();
        addr = 16'h00FC; data_in = 8'h02; niorq = 1'b0; nwr = 1'b0;
        repeat (10) tick();
        data_in = 8'h06;
        repeat (10) tick();
        niorq = 1'b1; nwr = 1'b1;
        repeat (2) tick();
        mseg[0] = 3'd2;
        mem_rd("long", 16'h0000, 17'h08000);

        // Reset during a write, released while the strobe is still low
        tick();
        addr = 16'h00FC; data_in = 8'h07; niorq = 1'b0; nwr = 1'b0;
        tick();
        rst = 1'b1;
        model_reset();
        repeat (2) tick();
        rst = 1'b0;
        repeat (5) tick();
        @(negedge clk);
        check("rstmid", 32'(ram_addr), 32'h0C0FC);
        tick();
        niorq = 1'b1; nwr = 1'b1;
        repeat (2) tick();
        for (int p = 0; p < 4; p++) begin
            logic [15:0] a;
            a = 16'(p) << 14;
            mem_rd("rstmid_pg", a, map_addr(a));
        end
        io_out(8'hFC, 8'h00, 8'h07, 3, 2);
        mem_rd("rewr", 16'h0010, 17'h1C010);

        // Randomised mix against the reference model
        for (int it = 0; it < 80; it++) begin
            int          op;
            logic [15:0] a;
            op = int'($urandom_range(0, 5));
            a  = 16'($urandom);
            case (op)
                0, 1: begin
                    logic [1:0] k;
                    k = 2'($urandom_range(0, 3));
                    io_out({6'h3F, k}, 8'($urandom), 8'($urandom),
                           int'($urandom_range(3, 6)), int'($urandom_range(2, 4)));
                    if (op == 1) io_in(k);
                end
                2: io_out(8'($urandom_range(0, 8'hFB)), 8'($urandom), 8'($urandom), 3, 2);
                3: mem_rd("rnd_rd", a, map_addr(a));
                4: begin
                    addr = a; nsltsel3 = 1'b0; niorq = 1'b1; nwr = 1'b0;
                    @(negedge clk);
                    check("rnd_wr", {ram_nce, ram_noe, ram_nwe, ram_addr}, {3'b010, map_addr(a)});
                    nwr = 1'b1; nsltsel3 = 1'b1;
                    tick();
                end
                default: begin
                    addr = a; nsltsel3 = 1'b1; niorq = 1'b1; nrd = 1'b0;
                    @(negedge clk);
                    check("rnd_desel", {ram_nce, ram_noe, ram_nwe}, 3'b111);
                    nrd = 1'b1;
                    tick();
                end
            endcase
        end

        for (int p = 0; p < 4; p++) begin
            logic [15:0] a;
            a = (16'(p) << 14) | 16'h0ABC;
            mem_rd("final_pg", a, map_addr(a));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_msx_mapper_ram
`default_nettype wire

// File: doc/msx_mapper_ram.md
# msx_mapper_ram

Parametrised MSX2-style memory-mapped RAM controller for slot 3, replacing the fixed 64 KB two-bank decode. Four page registers at I/O ports 0xFC–0xFF select which 16 KB segment of external SRAM appears in each 16 KB CPU page. Bus strobes are synchronised to the system clock, and each I/O write updates exactly one register. Sits between the Z80 bus and the external SRAM array; the upstream slot decoder drives nsltsel3.

## Interface
- SEG_BITS, 3, segment-number width, legal 1..8; RAM size = 2^SEG_BITS × 16 KB (default 128 KB)
- IO_BASE, 8'hFC, first mapper port; ports IO_BASE..IO_BASE+3 map to pages 0..3
- clk  in  1  system clock; all Z80 inputs are sampled on its rising edge
- rst  in  1  reset, asynchronous, active-high
- nsltsel3  in  1  slot-3 select, active-low
- niorq, nrd, nwr  in  1  Z80 strobes, active-low
- addr  in  16  Z80 address bus
- data_in  in  8  Z80 data bus, input side
- data_out  out  8  register readback value
- data_oe  out  1  high when data_out must drive the bus
- ram_addr  out  SEG_BITS+14  SRAM address
- ram_nce, ram_noe, ram_nwe  out  1  SRAM controls, active-low

## Operation
- Memory path is combinational: page p = addr[15:14]; ram_addr = {seg[p], addr[13:0]}.
- ram_nce = nsltsel3 | ~niorq (deselected during I/O cycles); ram_noe = nrd | ram_nce; ram_nwe = nwr | ram_nce.
- Write path: io_wr = ~niorq & ~nwr & (addr[7:2] == IO_BASE[7:2]). It passes through a 2-flop synchroniser and then a previous-value flop. A write fires on the cycle where the synchronised io_wr = 1 and the previous value = 0.
- When a write fires, seg[addr[1:0]] ← data_in[SEG_BITS-1:0]. data_in bits above SEG_BITS are discarded.
- addr and data_in are sampled directly at the firing cycle. The Z80 holds both stable for the whole nwr pulse.
- A strobe held low for any length produces exactly one write. A new write needs io_wr to deassert for ≥1 synchronised cycle first.
- Reset values: seg[0]=3, seg[1]=2, seg[2]=1, seg[3]=0, each truncated to SEG_BITS. data_out=0, data_oe=0.
- Synchroniser and previous-value flops reset to 1 (asserted). A strobe that is already low when rst is released does not fire a write.
- Reset asserted mid-write aborts the write; registers take their reset values immediately.

## Timing
- Write latency: io_wr first sampled low at edge N (sync stage 1). The register updates at edge N+2, and ram_addr shows the new value after edge N+2.
- Memory accesses before edge N+2 use the old segment, including accesses to the page being rewritten.
- Minimum nwr/niorq low time is 3 clk. Minimum high time between writes is 2 clk.
- Memory path has no clock latency. The required SRAM access time is the Z80 strobe window minus the combinational delay.

## Configuration
- MSX_MAPPER_READBACK_EN
  - Defined: an I/O read of port IO_BASE+k (~niorq & ~nrd, port match) raises data_oe combinationally.
  - data_out = {all-ones in bits above SEG_BITS, seg[k]}, registered each clk from the current seg.
  - data_out reflects a write from edge N+3 onward.
- Undefined: data_oe is tied 0 and data_out is tied 0. Port reads float, as on write-only mappers.

## Structure
- Package msx_mapper_pkg holds:
  - MAPPER_IO_BASE default (8'hFC)
  - page-index type (2 bits)
  - function giving the reset segment for page p, truncated to SEG_BITS
- One sub-module, msx_strobe_sync: 2-flop synchroniser plus falling-edge pulse generator. Its reset value is a parameter (used here as asserted).
- Top module holds:
  - the seg register array
  - port decode
  - memory-path muxing
  - readback

## Test plan
- Reset with SEG_BITS=3: read 0x0000, 0x4000, 0x8000, 0xC000 in slot 3 → ram_addr = 0x0C000, 0x08000, 0x04000, 0x00000.
- OUT (0xFE),0x05 then memory read 0x8123 → ram_addr = 0x14123; memory read 0x8123 issued 1 clk after niorq falls → old value 0x04123.
- OUT (0xFD),0xFF with SEG_BITS=3 → seg[1]=7; read 0x7FFF → ram_addr = 0x1FFFF.
- niorq/nwr held low 20 clk on port 0xFC while data_in changes from 0x02 to 0x06 at clk 10 → exactly one write, seg[0]=2.
- MSX_MAPPER_READBACK_EN defined: after OUT (0xFF),0x06, IN (0xFF) → data_oe=1, data_out=0xFE; nsltsel3 stays high during the write → no RAM select. Undefined: data_oe stays 0.
- Assert rst mid-write (io strobes low), release while still low → seg holds its reset values, no write fires until the strobe rises and falls again.
